// File: rtl/control_unit_multicycle_v2.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// ready-based wait states, a latched opcode, a trap state for illegal opcodes and
// memory timeouts, and a retired-instruction counter.
module control_unit_multicycle_v2 #(
    parameter int OPCODE_W = 5,
    parameter int R_MAX    = 6,
    parameter int OP_BEQ   = 7,
    parameter int OP_BNE   = 8,
    parameter int OP_LOAD  = 9,
    parameter int OP_STORE = 10,
    parameter int OP_JUMP  = 11,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                IR_enable,
    output logic                reg_enable,
    output logic                reg_write,
    output logic                ALU_src,
    output logic                immediate_signal,
    output logic                branch,
    output logic                jump,
    output logic                mem_enable,
    output logic                load,
    output logic                mem_write,
    output logic                PC_enable,
    output logic                instr_done,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [2:0]          state_out,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [OPCODE_W-1:0] R_MAX_C = OPCODE_W'(R_MAX);
    localparam logic [OPCODE_W-1:0] BEQ_C   = OPCODE_W'(OP_BEQ);
    localparam logic [OPCODE_W-1:0] BNE_C   = OPCODE_W'(OP_BNE);
    localparam logic [OPCODE_W-1:0] LOAD_C  = OPCODE_W'(OP_LOAD);
    localparam logic [OPCODE_W-1:0] STORE_C = OPCODE_W'(OP_STORE);
    localparam logic [OPCODE_W-1:0] JUMP_C  = OPCODE_W'(OP_JUMP);
    localparam logic [WAIT_W-1:0]   TMO_C   = WAIT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_BR, C_LD, C_ST, C_JMP, C_ILL
    } cls_t;

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [1:0]          cause_q, cause_d;
    logic [CNT_W-1:0]    count_q, count_d;
    cls_t                cls;
    logic                timeout_hit;

    logic imem_req_c, ir_en_c, reg_en_c, reg_wr_c, alu_src_c, imm_c;
    logic branch_c, jump_c, mem_en_c, load_c, mem_wr_c, pc_en_c, trap_c;

    // Classify the latched opcode; R-type range takes priority over the MSB immediate rule
    always_comb begin
        cls = C_ILL;
        if (opcode_q <= R_MAX_C)                       cls = C_R;
        else if (opcode_q[OPCODE_W-1])                 cls = C_I;
        else if (opcode_q == BEQ_C || opcode_q == BNE_C) cls = C_BR;
        else if (opcode_q == LOAD_C)                   cls = C_LD;
        else if (opcode_q == STORE_C)                  cls = C_ST;
        else if (opcode_q == JUMP_C)                   cls = C_JMP;
    end

    assign timeout_hit = (TIMEOUT != 0) && (wait_q == TMO_C);

    // Next-state, wait counter and datapath enables; a ready arriving on the timeout cycle wins
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        wait_d     = '0;
        cause_d    = cause_q;
        imem_req_c = 1'b0;
        ir_en_c    = 1'b0;
        reg_en_c   = 1'b0;
        reg_wr_c   = 1'b0;
        alu_src_c  = 1'b0;
        imm_c      = 1'b0;
        branch_c   = 1'b0;
        jump_c     = 1'b0;
        mem_en_c   = 1'b0;
        load_c     = 1'b0;
        mem_wr_c   = 1'b0;
        pc_en_c    = 1'b0;
        trap_c     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                ir_en_c    = imem_ready;
                if (imem_ready) begin
                    opcode_d = opcode;
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                reg_en_c = 1'b1;
                if (cls == C_ILL) begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (cls)
                    C_R:  begin alu_src_c = 1'b1; state_d = S_WRITEBACK; end
                    C_I:  begin imm_c = 1'b1; state_d = S_WRITEBACK; end
                    C_BR: begin
                        alu_src_c = 1'b1;
                        branch_c  = 1'b1;
                        pc_en_c   = 1'b1;
                        state_d   = S_FETCH;
                    end
                    C_JMP: begin
                        jump_c  = 1'b1;
                        pc_en_c = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_LD, C_ST: begin alu_src_c = 1'b1; state_d = S_MEMORY; end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMORY: begin
                mem_en_c = 1'b1;
                if (cls == C_LD) begin
                    load_c = 1'b1;
                    imm_c  = 1'b1;
                end else begin
                    mem_wr_c = 1'b1;
                end
                if (dmem_ready) begin
                    if (cls == C_LD) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        pc_en_c = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WRITEBACK: begin
                reg_en_c = 1'b1;
                reg_wr_c = 1'b1;
                pc_en_c  = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                trap_c = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign count_d = count_q + (pc_en_c ? CNT_W'(1) : CNT_W'(0));

    // State, latched opcode, wait counter, trap cause and retire counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            wait_q   <= '0;
            cause_q  <= 2'd0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            wait_q   <= wait_d;
            cause_q  <= cause_d;
            count_q  <= count_d;
        end
    end

    assign imem_req         = reset & imem_req_c;
    assign IR_enable        = reset & ir_en_c;
    assign reg_enable       = reset & reg_en_c;
    assign reg_write        = reset & reg_wr_c;
    assign ALU_src          = reset & alu_src_c;
    assign immediate_signal = reset & imm_c;
    assign branch           = reset & branch_c;
    assign jump             = reset & jump_c;
    assign mem_enable       = reset & mem_en_c;
    assign load             = reset & load_c;
    assign mem_write        = reset & mem_wr_c;
    assign PC_enable        = reset & pc_en_c;
    assign instr_done       = reset & pc_en_c;
    assign trap             = reset & trap_c;
    assign trap_cause       = cause_q;
    assign state_out        = state_q;
    assign instr_count      = count_q;

endmodule

// File: tb/tb_control_unit_multicycle_v2.sv
// Directed bench for control_unit_multicycle_v2: per-cycle vector table plus
// hand-written sequences for reset abort, illegal trap and wait-state timeouts.
module tb_control_unit_multicycle_v2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  opcode = '0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, IR_enable, reg_enable, reg_write, ALU_src, immediate_signal;
    logic        branch, jump, mem_enable, load, mem_write, PC_enable, instr_done, trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state_out;
    logic [15:0] instr_count;
    logic [13:0] outs;

    int checks = 0;
    int errors = 0;

    control_unit_multicycle_v2 dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .IR_enable(IR_enable), .reg_enable(reg_enable),
        .reg_write(reg_write), .ALU_src(ALU_src), .immediate_signal(immediate_signal),
        .branch(branch), .jump(jump), .mem_enable(mem_enable), .load(load),
        .mem_write(mem_write), .PC_enable(PC_enable), .instr_done(instr_done),
        .trap(trap), .trap_cause(trap_cause), .state_out(state_out),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // {imem_req,IR_en,reg_en,reg_wr}_{ALU_src,imm,branch,jump}_{mem_en,load,mem_wr,PC_en}_{done,trap}
    assign outs = {imem_req, IR_enable, reg_enable, reg_write,
                   ALU_src, immediate_signal, branch, jump,
                   mem_enable, load, mem_write, PC_enable,
                   instr_done, trap};

    localparam logic [13:0] P_NONE = 14'b0000_0000_0000_00;
    localparam logic [13:0] P_F1   = 14'b1100_0000_0000_00;
    localparam logic [13:0] P_F0   = 14'b1000_0000_0000_00;
    localparam logic [13:0] P_DEC  = 14'b0010_0000_0000_00;
    localparam logic [13:0] P_XR   = 14'b0000_1000_0000_00;
    localparam logic [13:0] P_XI   = 14'b0000_0100_0000_00;
    localparam logic [13:0] P_XB   = 14'b0000_1010_0001_10;
    localparam logic [13:0] P_XJ   = 14'b0000_0001_0001_10;
    localparam logic [13:0] P_MLD  = 14'b0000_0100_1100_00;
    localparam logic [13:0] P_MST0 = 14'b0000_0000_1010_00;
    localparam logic [13:0] P_MST1 = 14'b0000_0000_1011_10;
    localparam logic [13:0] P_WB   = 14'b0011_0000_0001_10;
    localparam logic [13:0] P_TRAP = 14'b0000_0000_0000_01;

    typedef struct {
        logic [4:0]  op;
        logic        ir;
        logic        dr;
        logic [2:0]  st;
        logic [13:0] o;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[40];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Assert reset with inputs that would otherwise drive outputs, check, release after an edge
    task automatic do_reset(input string tag);
        opcode = 5'd3;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        reset = 1'b0;
        #1;
        chk({tag, "_rst_outs"}, outs, P_NONE);
        chk({tag, "_rst_state"}, state_out, 3'd0);
        chk({tag, "_rst_cause"}, trap_cause, 2'd0);
        chk({tag, "_rst_cnt"}, instr_count, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        reset = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{5'd3,  1'b1, 1'b0, 3'd0, P_F1,   16'd0};
        vecs[1]  = '{5'd12, 1'b1, 1'b0, 3'd1, P_DEC,  16'd0};
        vecs[2]  = '{5'd12, 1'b1, 1'b0, 3'd2, P_XR,   16'd0};
        vecs[3]  = '{5'd12, 1'b1, 1'b1, 3'd4, P_WB,   16'd0};
        vecs[4]  = '{5'd9,  1'b1, 1'b0, 3'd0, P_F1,   16'd1};
        vecs[5]  = '{5'd9,  1'b1, 1'b0, 3'd1, P_DEC,  16'd1};
        vecs[6]  = '{5'd9,  1'b1, 1'b0, 3'd2, P_XR,   16'd1};
        vecs[7]  = '{5'd9,  1'b1, 1'b0, 3'd3, P_MLD,  16'd1};
        vecs[8]  = '{5'd9,  1'b1, 1'b0, 3'd3, P_MLD,  16'd1};
        vecs[9]  = '{5'd9,  1'b1, 1'b0, 3'd3, P_MLD,  16'd1};
        vecs[10] = '{5'd9,  1'b1, 1'b1, 3'd3, P_MLD,  16'd1};
        vecs[11] = '{5'd9,  1'b1, 1'b0, 3'd4, P_WB,   16'd1};
        vecs[12] = '{5'd10, 1'b1, 1'b1, 3'd0, P_F1,   16'd2};
        vecs[13] = '{5'd10, 1'b1, 1'b1, 3'd1, P_DEC,  16'd2};
        vecs[14] = '{5'd10, 1'b1, 1'b1, 3'd2, P_XR,   16'd2};
        vecs[15] = '{5'd10, 1'b1, 1'b1, 3'd3, P_MST1, 16'd2};
        vecs[16] = '{5'd8,  1'b1, 1'b0, 3'd0, P_F1,   16'd3};
        vecs[17] = '{5'd8,  1'b1, 1'b0, 3'd1, P_DEC,  16'd3};
        vecs[18] = '{5'd8,  1'b1, 1'b0, 3'd2, P_XB,   16'd3};
        vecs[19] = '{5'd11, 1'b1, 1'b0, 3'd0, P_F1,   16'd4};
        vecs[20] = '{5'd11, 1'b1, 1'b0, 3'd1, P_DEC,  16'd4};
        vecs[21] = '{5'd11, 1'b1, 1'b0, 3'd2, P_XJ,   16'd4};
        vecs[22] = '{5'd21, 1'b1, 1'b0, 3'd0, P_F1,   16'd5};
        vecs[23] = '{5'd21, 1'b1, 1'b0, 3'd1, P_DEC,  16'd5};
        vecs[24] = '{5'd21, 1'b1, 1'b0, 3'd2, P_XI,   16'd5};
        vecs[25] = '{5'd21, 1'b1, 1'b0, 3'd4, P_WB,   16'd5};
        vecs[26] = '{5'd7,  1'b0, 1'b0, 3'd0, P_F0,   16'd6};
        vecs[27] = '{5'd7,  1'b1, 1'b0, 3'd0, P_F1,   16'd6};
        vecs[28] = '{5'd7,  1'b1, 1'b0, 3'd1, P_DEC,  16'd6};
        vecs[29] = '{5'd7,  1'b1, 1'b0, 3'd2, P_XB,   16'd6};
        vecs[30] = '{5'd6,  1'b1, 1'b0, 3'd0, P_F1,   16'd7};
        vecs[31] = '{5'd6,  1'b1, 1'b0, 3'd1, P_DEC,  16'd7};
        vecs[32] = '{5'd6,  1'b1, 1'b0, 3'd2, P_XR,   16'd7};
        vecs[33] = '{5'd6,  1'b1, 1'b0, 3'd4, P_WB,   16'd7};
        vecs[34] = '{5'd10, 1'b1, 1'b0, 3'd0, P_F1,   16'd8};
        vecs[35] = '{5'd10, 1'b1, 1'b0, 3'd1, P_DEC,  16'd8};
        vecs[36] = '{5'd10, 1'b1, 1'b0, 3'd2, P_XR,   16'd8};
        vecs[37] = '{5'd10, 1'b1, 1'b0, 3'd3, P_MST0, 16'd8};
        vecs[38] = '{5'd10, 1'b1, 1'b1, 3'd3, P_MST1, 16'd8};
        vecs[39] = '{5'd0,  1'b0, 1'b0, 3'd0, P_F0,   16'd9};

        #2;
        do_reset("tbl");
        for (int i = 0; i < 40; i++) begin
            opcode = vecs[i].op;
            imem_ready = vecs[i].ir;
            dmem_ready = vecs[i].dr;
            @(negedge clk);
            chk($sformatf("v%0d_state", i), state_out, vecs[i].st);
            chk($sformatf("v%0d_outs", i), outs, vecs[i].o);
            chk($sformatf("v%0d_cause", i), trap_cause, 2'd0);
            chk($sformatf("v%0d_cnt", i), instr_count, vecs[i].cnt);
            next_cycle();
        end

        // Reset during WRITEBACK aborts the instruction without retiring it
        do_reset("abort");
        opcode = 5'd3;
        imem_ready = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("abort_wb_state", state_out, 3'd4);
        chk("abort_wb_pc", PC_enable, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_outs", outs, P_NONE);
        chk("abort_state", state_out, 3'd0);
        @(posedge clk);
        #1;
        chk("abort_cnt", instr_count, 16'd0);
        reset = 1'b1;

        // Illegal opcode traps after DECODE and holds
        opcode = 5'd12;
        imem_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("ill_decode", state_out, 3'd1);
        next_cycle();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("ill_hold%0d_state", k), state_out, 3'd5);
            chk($sformatf("ill_hold%0d_outs", k), outs, P_TRAP);
            chk($sformatf("ill_hold%0d_cause", k), trap_cause, 2'd1);
            next_cycle();
        end
        #1;
        reset = 1'b0;
        #1;
        chk("ill_rst_outs", outs, P_NONE);
        chk("ill_rst_state", state_out, 3'd0);
        chk("ill_rst_cause", trap_cause, 2'd0);
        next_cycle();
        reset = 1'b1;

        // Instruction fetch never ready: 16 FETCH cycles then TRAP cause 2
        do_reset("ftmo");
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("ftmo_wait%0d", k), state_out, 3'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("ftmo_state", state_out, 3'd5);
        chk("ftmo_cause", trap_cause, 2'd2);
        chk("ftmo_outs", outs, P_TRAP);

        // Ready arriving on the timeout cycle wins
        do_reset("frace");
        for (int k = 0; k < 15; k++) next_cycle();
        opcode = 5'd3;
        imem_ready = 1'b1;
        @(negedge clk);
        chk("frace_fetch", state_out, 3'd0);
        next_cycle();
        @(negedge clk);
        chk("frace_decode", state_out, 3'd1);
        chk("frace_notrap", trap, 1'b0);
        chk("frace_cause", trap_cause, 2'd0);

        // Data memory never ready on a load: 16 MEMORY cycles then TRAP cause 2
        do_reset("mtmo");
        opcode = 5'd9;
        imem_ready = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("mtmo_wait%0d", k), state_out, 3'd3);
            next_cycle();
        end
        @(negedge clk);
        chk("mtmo_state", state_out, 3'd5);
        chk("mtmo_cause", trap_cause, 2'd2);
        chk("mtmo_cnt", instr_count, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
